// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, word-length codes and parity decode for the UART transmitter
package uart_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Word-length select codes
   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   // Parity modes decoded from pen/eps/sp
   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_ODD,
      PAR_EVEN,
      PAR_STICK
   } par_mode_e;

   localparam logic UART_IDLE_LVL = 1'b1;

   // Keeps only the bits that belong to the selected word length
   function automatic logic [7:0] wls_mask(input logic [1:0] wls);
      return 8'hFF >> (WLS_8 - wls);
   endfunction

   function automatic par_mode_e par_decode(input logic pen, input logic eps, input logic sp);
      if (!pen) return PAR_NONE;
      if (sp) return PAR_STICK;
      return eps ? PAR_EVEN : PAR_ODD;
   endfunction

   // Parity bit for already-masked data; stick parity sends the complement of eps
   function automatic logic par_value(input logic [7:0] masked, input par_mode_e mode, input logic eps);
      case (mode)
         PAR_EVEN:  return ^masked;
         PAR_ODD:   return ~(^masked);
         PAR_STICK: return ~eps;
         default:   return UART_IDLE_LVL;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead byte FIFO with occupancy, full and empty
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    wr_data,
   input  logic          wr_en,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_wr;
   logic        do_rd;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = CW'(wr_ptr - rd_ptr);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   // Storage array, written only when there is room
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Pointer update; a write while full is refused even if a read happens in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter core; define UART_TX_FIFO_EN for a FIFO_DEPTH FIFO, else a single holding register
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                               i_sys_clk,
   input  logic                               i_sys_rst,
   input  logic [7:0]                         i_data,
   input  logic                               i_flag,
   output logic                               o_ready,
   output logic                               o_drop,
   input  logic [DIV_W-1:0]                   i_divisor,
   input  logic [1:0]                         i_wls,
   input  logic                               i_stb,
   input  logic                               i_pen,
   input  logic                               i_eps,
   input  logic                               i_sp,
   input  logic                               i_break,
   output logic                               o_tx,
   output logic                               o_finsh_flag,
   output logic                               o_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_cnt,
   output logic                               o_empty,
   output logic                               o_temt
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [7:0]       q_data;
   logic             q_full;
   logic             q_empty;
   logic [CW-1:0]    q_cnt;
   logic             pop;

   tx_state_e        state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_m1;
   logic [DIV_W-1:0] div_eff;
   logic [2:0]       bit_idx;
   logic [2:0]       last_idx;
   logic             stb_l;
   logic             pen_l;
   logic             par_l;
   logic [7:0]       shreg;
   logic             done_r;
   logic             line_bit;

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (i_sys_clk),
      .rst     (i_sys_rst),
      .wr_data (i_data),
      .wr_en   (i_flag),
      .rd_en   (pop),
      .rd_data (q_data),
      .full    (q_full),
      .empty   (q_empty),
      .count   (q_cnt)
   );
`else
   logic [7:0] hold_data;
   logic       hold_vld;

   // Single-entry holding register; a write while occupied is refused even if it empties this cycle
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         hold_data <= '0;
         hold_vld  <= 1'b0;
      end else if (i_flag && !hold_vld) begin
         hold_data <= i_data;
         hold_vld  <= 1'b1;
      end else if (pop) begin
         hold_vld  <= 1'b0;
      end
   end

   assign q_data  = hold_data;
   assign q_full  = hold_vld;
   assign q_empty = !hold_vld;
   assign q_cnt   = {{(CW-1){1'b0}}, hold_vld};
`endif

   assign o_ready    = !q_full;
   assign o_empty    = q_empty;
   assign o_fifo_cnt = q_cnt;
   assign o_temt     = q_empty && (state == IDLE) && !o_busy;
   assign div_eff    = (i_divisor == '0) ? DIV_W'(1) : i_divisor;

   // A word leaves the queue when idle, or at the end of the last stop bit so frames run back to back
   assign pop = !q_empty && ((state == IDLE) ||
                ((state == STOP) && (cnt == '0) && (bit_idx[0] == stb_l)));

   // Line level implied by the current state; o_tx follows it one edge later
   always_comb begin
      line_bit = UART_IDLE_LVL;
      case (state)
         START:   line_bit = 1'b0;
         DATA:    line_bit = shreg[0];
         PARITY:  line_bit = par_l;
         default: line_bit = UART_IDLE_LVL;
      endcase
   end

   // Frame sequencer with registered line, busy, drop and completion outputs
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         div_m1       <= '0;
         bit_idx      <= '0;
         last_idx     <= '0;
         stb_l        <= 1'b0;
         pen_l        <= 1'b0;
         par_l        <= 1'b0;
         shreg        <= '0;
         done_r       <= 1'b0;
         o_tx         <= UART_IDLE_LVL;
         o_busy       <= 1'b0;
         o_finsh_flag <= 1'b0;
         o_drop       <= 1'b0;
      end else begin
         o_tx         <= i_break ? 1'b0 : line_bit;
         o_busy       <= (state != IDLE);
         o_finsh_flag <= done_r;
         o_drop       <= i_flag && q_full;
         done_r       <= 1'b0;
         if ((state != IDLE) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (pop) state <= START;
               end
               START: begin
                  cnt     <= div_m1;
                  bit_idx <= '0;
                  state   <= DATA;
               end
               DATA: begin
                  cnt   <= div_m1;
                  shreg <= shreg >> 1;
                  if (bit_idx == last_idx) begin
                     bit_idx <= '0;
                     state   <= pen_l ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
               PARITY: begin
                  cnt     <= div_m1;
                  bit_idx <= '0;
                  state   <= STOP;
               end
               STOP: begin
                  if (bit_idx[0] == stb_l) begin
                     done_r <= 1'b1;
                     state  <= pop ? START : IDLE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     cnt     <= div_m1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
         if (pop) begin
            shreg    <= q_data & wls_mask(i_wls);
            last_idx <= 3'd4 + {1'b0, i_wls};
            stb_l    <= i_stb;
            pen_l    <= i_pen;
            par_l    <= par_value(q_data & wls_mask(i_wls), par_decode(i_pen, i_eps, i_sp), i_eps);
            div_m1   <= div_eff - 1'b1;
            cnt      <= div_eff - 1'b1;
            bit_idx  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core (adapts to UART_TX_FIFO_EN)
module tb_uart_tx_core;

`ifdef UART_TX_FIFO_EN
   localparam int CAP = 16;
`else
   localparam int CAP = 1;
`endif
   localparam int CW = $clog2(16 + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    data = '0;
   logic          flag = 1'b0;
   logic          ready;
   logic          drop;
   logic [15:0]   divisor = 16'd4;
   logic [1:0]    wls = 2'b11;
   logic          stb = 1'b0;
   logic          pen = 1'b0;
   logic          eps = 1'b0;
   logic          sp = 1'b0;
   logic          brk = 1'b0;
   logic          tx;
   logic          finsh;
   logic          busy;
   logic [CW-1:0] fifo_cnt;
   logic          empty;
   logic          temt;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_core #(
      .FIFO_DEPTH (16),
      .DIV_W      (16)
   ) dut (
      .i_sys_clk    (clk),
      .i_sys_rst    (rst),
      .i_data       (data),
      .i_flag       (flag),
      .o_ready      (ready),
      .o_drop       (drop),
      .i_divisor    (divisor),
      .i_wls        (wls),
      .i_stb        (stb),
      .i_pen        (pen),
      .i_eps        (eps),
      .i_sp         (sp),
      .i_break      (brk),
      .o_tx         (tx),
      .o_finsh_flag (finsh),
      .o_busy       (busy),
      .o_fifo_cnt   (fifo_cnt),
      .o_empty      (empty),
      .o_temt       (temt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit idx of a frame: start, nb data bits LSB first, optional parity, then stop bits
   function automatic logic exp_frame_bit(input logic [7:0] d, input int nb, input bit p_en,
                                          input bit p_eps, input bit p_sp, input int idx);
      logic x;
      x = 1'b0;
      for (int i = 0; i < nb; i++) x ^= d[i];
      if (idx == 0) return 1'b0;
      if (idx <= nb) return d[idx-1];
      if (p_en && idx == nb + 1) return p_sp ? ~p_eps : (p_eps ? x : ~x);
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else n_pass++;
      n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
      n_checks++; if (temt !== 1'b1) $display("FAIL reset_temt got %b want 1", temt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (finsh !== 1'b0) $display("FAIL reset_finsh got %b want 0", finsh); else n_pass++;
      n_checks++; if (drop !== 1'b0) $display("FAIL reset_drop got %b want 0", drop); else n_pass++;
      n_checks++; if (fifo_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", fifo_cnt); else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   // One frame written at edge k with the DUT idle; o_tx and o_finsh_flag are recorded after edges k+1..k+len+2.
   // bs..be is the range of edges (relative to k) at which i_break is held high.
   task automatic run_frame(input string name, input logic [7:0] d, input int dv, input logic [1:0] w,
                            input bit s2, input bit p_en, input bit p_eps, input bit p_sp,
                            input int bs, input int be, input bit scramble);
      int div_e, nb, len, first;
      logic [1023:0] exp_tx, act_tx, exp_fin, act_fin;
      logic b;
      div_e = (dv == 0) ? 1 : dv;
      nb = 5 + int'(w);
      len = (2 + nb + int'(p_en) + int'(s2)) * div_e;
      exp_tx = '1; act_tx = '1; exp_fin = '0; act_fin = '0;
      for (int c = 1; c <= len + 2; c++) begin
         b = 1'b1;
         if (c >= 2 && c < 2 + len) b = exp_frame_bit(d, nb, p_en, p_eps, p_sp, (c - 2) / div_e);
         if (c >= bs && c <= be) b = 1'b0;
         exp_tx[c-1] = b;
         exp_fin[c-1] = (c == len + 2);
      end
      divisor = 16'(dv); wls = w; stb = s2; pen = p_en; eps = p_eps; sp = p_sp;
      data = d; flag = 1'b1;
      tick();
      flag = 1'b0; data = 8'($urandom);
      for (int c = 1; c <= len + 2; c++) begin
         brk = (c >= bs && c <= be);
         tick();
         act_tx[c-1] = tx;
         act_fin[c-1] = finsh;
         if (scramble) begin
            divisor = 16'($urandom_range(0, 9));
            wls = 2'($urandom); stb = 1'($urandom); pen = 1'($urandom);
            eps = 1'($urandom); sp = 1'($urandom);
         end
      end
      brk = 1'b0;
      n_checks++;
      if (act_tx !== exp_tx) begin
         first = 0;
         for (int i = len + 1; i >= 0; i--) if (act_tx[i] !== exp_tx[i]) first = i + 1;
         $display("FAIL %s line at edge k+%0d got %b want %b", name, first, act_tx[first-1], exp_tx[first-1]);
      end else n_pass++;
      n_checks++;
      if (act_fin !== exp_fin) begin
         first = 0;
         for (int i = len + 1; i >= 0; i--) if (act_fin[i] !== exp_fin[i]) first = i + 1;
         $display("FAIL %s finsh at edge k+%0d got %b want %b", name, first, act_fin[first-1], exp_fin[first-1]);
      end else n_pass++;
   endtask

   task automatic test_fixed_frames();
      run_frame("s1_8n1_55", 8'h55, 4, 2'b11, 0, 0, 0, 0, -1, -1, 0);
      run_frame("s2_7e2_03", 8'h03, 2, 2'b10, 1, 1, 1, 0, -1, -1, 0);
      run_frame("s4_stick_eps1", 8'h1F, 3, 2'b00, 0, 1, 1, 1, -1, -1, 0);
      run_frame("s4_stick_eps0", 8'h1F, 3, 2'b00, 0, 1, 0, 1, -1, -1, 0);
   endtask

   task automatic test_break();
      run_frame("s5_break", 8'($urandom), 4, 2'b11, 0, 0, 0, 0, 18, 25, 0);
   endtask

   task automatic test_random_frames();
      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("rand%0d", i), 8'($urandom), (i == 0) ? 0 : int'($urandom_range(1, 4)),
                   2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1, -1, 1);
      end
   endtask

   // 18 writes on consecutive edges e0..e17 at divisor 100, 8N1; e0 is c = 0
   task automatic test_back_to_back();
      int cnt_m, n_acc, err_hs, err_tx, err_fin, first_tx, c, f, bi;
      bit full_m, pop_m, exp_b, exp_f;
      logic [7:0] d;
      logic [7:0] q[$];
      divisor = 16'd100; wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0;
      cnt_m = 0; n_acc = 0; err_hs = 0; err_tx = 0; err_fin = 0; first_tx = -1; c = 0;
      while (c < 18 || c <= 2 + n_acc * 1000) begin
         full_m = 1'b0;
         d = 8'h00;
         if (c < 18) begin
            full_m = (cnt_m == CAP);
            if (ready !== !full_m) begin
               err_hs++;
               $display("FAIL b2b_ready write %0d got %b want %b", c, ready, !full_m);
            end
            d = 8'($urandom);
            data = d; flag = 1'b1;
         end else begin
            flag = 1'b0;
         end
         tick();
         if (c < 18) begin
            // the only frame start inside the burst is at e1, when the idle sequencer takes the first word
            pop_m = (c == 1) && (cnt_m > 0);
            if (!full_m) begin
               q.push_back(d);
               n_acc++;
            end
            cnt_m = cnt_m + (full_m ? 0 : 1) - (pop_m ? 1 : 0);
            if (drop !== full_m) err_hs++;
            if (fifo_cnt !== CW'(cnt_m)) err_hs++;
         end
         exp_b = 1'b1;
         if (c >= 2 && c < 2 + n_acc * 1000) begin
            f = (c - 2) / 1000;
            bi = ((c - 2) % 1000) / 100;
            exp_b = exp_frame_bit(q[f], 8, 0, 0, 0, bi);
         end
         if (tx !== exp_b) begin
            err_tx++;
            if (first_tx < 0) first_tx = c;
         end
         exp_f = (c >= 1002) && ((c - 2) % 1000 == 0) && ((c - 2) / 1000 <= n_acc);
         if (finsh !== exp_f) err_fin++;
         c++;
      end
      n_checks++; if (err_hs != 0) $display("FAIL b2b_handshake errors got %0d want 0", err_hs); else n_pass++;
      n_checks++; if (n_acc != ((CAP > 1) ? 17 : 2) || err_tx != 0)
         $display("FAIL b2b_line bad cycles got %0d want 0 (first e%0d, accepted %0d)", err_tx, first_tx, n_acc);
      else n_pass++;
      n_checks++; if (err_fin != 0) $display("FAIL b2b_finsh bad cycles got %0d want 0", err_fin); else n_pass++;
      n_checks++; if (temt !== 1'b1) $display("FAIL b2b_temt got %b want 1", temt); else n_pass++;
   endtask

   // Reset during the data bits with more words waiting
   task automatic test_reset_mid_frame();
      int err;
      divisor = 16'd4; wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0;
      for (int c = 0; c < 10; c++) begin
         flag = (c == 0 || c == 2 || c == 3 || c == 4);
         data = 8'($urandom);
         tick();
      end
      flag = 1'b0;
      rst = 1'b1;
      tick();
      n_checks++; if (tx !== 1'b1) $display("FAIL rstmid_tx got %b want 1", tx); else n_pass++;
      n_checks++; if (fifo_cnt !== '0) $display("FAIL rstmid_cnt got %0d want 0", fifo_cnt); else n_pass++;
      n_checks++; if (temt !== 1'b1) $display("FAIL rstmid_temt got %b want 1", temt); else n_pass++;
      n_checks++; if (finsh !== 1'b0) $display("FAIL rstmid_finsh got %b want 0", finsh); else n_pass++;
      n_checks++; if (ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_ready_busy got %b%b want 10", ready, busy); else n_pass++;
      rst = 1'b0;
      err = 0;
      for (int c = 0; c < 80; c++) begin
         tick();
         if (finsh !== 1'b0 || tx !== 1'b1) err++;
      end
      n_checks++; if (err != 0) $display("FAIL rstmid_quiet bad cycles got %0d want 0", err); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fixed_frames();
      test_break();
      test_random_frames();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, transmit FIFO entries (power of two, 2..256).
REQ-002 Parameter DIV_W, default 16, width of baud divisor.
REQ-003 i_sys_clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-004 i_sys_rst  input  1  reset; synchronous and active-high.
REQ-005 i_data  input  8  transmit word; bits above the selected word length are ignored.
REQ-006 i_flag  input  1  write strobe; one word is written per high cycle.
REQ-007 o_ready  output  1  high when a write is accepted (FIFO not full).
REQ-008 o_drop  output  1  one-cycle pulse when a write is discarded.
REQ-009 i_divisor  input  DIV_W  clock cycles per bit; 0 is treated as 1.
REQ-010 i_wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-011 i_stb  input  1  stop bits: 0=1, 1=2.
REQ-012 i_pen, i_eps, i_sp  input  1 each  parity enable, even select, stick parity.
REQ-013 i_break  input  1  forces o_tx low.
REQ-014 o_tx  output  1  serial line; idle high.
REQ-015 o_finsh_flag  output  1  one-cycle pulse per completed frame.
REQ-016 o_busy  output  1  high while a frame is on the line.
REQ-017 o_fifo_cnt  output  clog2(FIFO_DEPTH+1)  FIFO occupancy.
REQ-018 o_empty, o_temt  output  1 each  FIFO empty; FIFO empty and shifter idle.

Function
REQ-019 The FSM SHALL use the states IDLE, START, DATA, PARITY, and STOP.
REQ-020 IDLE->START when the FIFO is non-empty: the head word is popped, and the divisor, wls, stb, pen, eps and sp inputs are latched for the whole frame.
REQ-021 START->DATA->PARITY (if pen) ->STOP; DATA covers 5..8 bits, LSB first.
REQ-022 STOP lasts 1 or 2 bit times; on exit the FSM goes to START if the FIFO is non-empty, with no idle gap, otherwise to IDLE.
REQ-023 Every bit lasts exactly the latched divisor cycles, measured by a down-counter.
REQ-024 Parity: the XOR of the selected data bits, with these rules:
- Even: the XOR value.
- Odd: the inverted XOR value.
- Stick (sp=1): the bit is ~eps.
REQ-025 Latency: for a write accepted at edge k with the FSM idle, o_tx SHALL fall at edge k+2.
REQ-026 o_finsh_flag SHALL be registered high for one cycle at the edge that ends the final stop bit.
REQ-027 A write when full SHALL be dropped with o_drop pulsed, even if a pop occurs in the same cycle.
REQ-028 A simultaneous write and pop when not full SHALL keep o_fifo_cnt unchanged.
REQ-029 o_fifo_cnt SHALL wrap correctly at FIFO_DEPTH pointer boundaries.
REQ-030 i_break SHALL drive o_tx low combinationally-registered next edge; the FSM keeps timing and the frame content is lost.
REQ-031 Input changes mid-frame SHALL not affect the current frame.

Reset
REQ-032 While i_sys_rst is high at a clock edge, the block SHALL be reset as follows, including mid-frame:
- FSM: IDLE.
- FIFO: emptied.
- o_tx: 1.
- o_ready: 1.
- o_empty, o_temt: 1.
- o_busy, o_finsh_flag, o_drop: 0.
- o_fifo_cnt: 0.
- Counters: 0.

Configuration
REQ-033 Macro UART_TX_FIFO_EN: when defined, the FIFO has FIFO_DEPTH entries.
REQ-034 When UART_TX_FIFO_EN is undefined, a single holding register replaces the FIFO: o_fifo_cnt is 0/1 and o_ready = ~o_fifo_cnt[0]; all other behaviour is identical.

Structure
REQ-035 Package uart_pkg SHALL hold:
- the FSM state encoding;
- word-length codes;
- the parity-mode decode constants;
- UART_IDLE_LVL = 1.
REQ-036 Sub-module uart_tx_fifo (sync FIFO with count, full and empty outputs) SHALL be instantiated only under UART_TX_FIFO_EN.

Verification
REQ-037 Scenario 1: divisor=4, 8N1, write 0x55 at edge k.
- o_tx SHALL drive 0,1,0,1,0,1,0,1,0,1, 4 cycles each, starting at k+2.
- o_finsh_flag SHALL pulse at k+42.
REQ-038 Scenario 2: divisor=2, 7 bits, even parity, 2 stop, data 0x03.
- Bits SHALL be 0, 1,1,0,0,0,0,0, parity 0, 1, 1.
- The frame SHALL be 22 cycles.
REQ-039 Scenario 3: divisor=100, 18 back-to-back writes.
- 17 writes SHALL be accepted; write 18 SHALL pulse o_drop with o_ready low.
- 17 contiguous frames SHALL follow, then o_temt=1.
REQ-040 Scenario 4: 5 bits, pen=1, sp=1, eps=1, data 0x1F; the parity bit SHALL be 0, and 1 when eps=0.
REQ-041 Scenario 5: assert i_break during data bit 3.
- o_tx SHALL be low until release.
- o_finsh_flag SHALL still pulse at the nominal time.
REQ-042 Scenario 6: assert i_sys_rst mid-DATA with 3 words queued; at the next edge o_tx=1, o_fifo_cnt=0, o_temt=1, and there SHALL be no o_finsh_flag.
